// File: rtl/pulse_list_reader.sv
// Streams one bank of pulse-list BRAM entries to the PC as a header word plus data words,
// keeping reads in flight plus buffered records within a 4-record window.
`timescale 1ns/1ps
module pulse_list_reader #(
    parameter int XB_SIZE         = 32,
    parameter int DATA_SIZE       = 64,
    parameter int N_ZMW           = 128,
    parameter int BRAM_READ_DELAY = 3
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     start,
    input  logic                     bank,
    output logic                     busy,
    output logic                     done,
    output logic                     bram_sel,
    output logic [$clog2(N_ZMW)-1:0] bram_addr,
    output logic                     bram_en,
    input  logic [DATA_SIZE-1:0]     bram_dout,
    output logic                     fpga_msg_valid,
    output logic [XB_SIZE-1:0]       fpga_msg,
    input  logic                     fpga_msg_ack
);
    localparam int AW  = $clog2(N_ZMW);
    localparam int NW  = DATA_SIZE / XB_SIZE;
    localparam int WCW = $clog2(NW + 1);
    localparam int D   = BRAM_READ_DELAY;

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

    state_t                    state_q, state_d;
    logic                      busy_q, busy_d, done_q, done_d;
    logic                      sel_q, sel_d, en_q, en_d;
    logic [AW-1:0]             addr_q, addr_d;
    logic [2:0]                credit_q, credit_d;
    logic [D-1:0]              dly_vld_q, dly_vld_d;
    logic [D-1:0][AW-1:0]      dly_idx_q, dly_idx_d;
    logic [3:0][AW-1:0]        fifo_idx_q, fifo_idx_d;
    logic [3:0][DATA_SIZE-1:0] fifo_dat_q, fifo_dat_d;
    logic [1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0]                fill_q, fill_d;
    logic                      msg_vld_q, msg_vld_d, last_q, last_d;
    logic [XB_SIZE-1:0]        msg_q, msg_d;
    logic [WCW-1:0]            widx_q, widx_d;
    logic                      accept, issue, push, pop, xfer;

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        sel_d      = sel_q;
        en_d       = 1'b0;
        addr_d     = addr_q;
        dly_vld_d  = dly_vld_q;
        dly_idx_d  = dly_idx_q;
        fifo_idx_d = fifo_idx_q;
        fifo_dat_d = fifo_dat_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        msg_vld_d  = msg_vld_q;
        msg_d      = msg_q;
        last_d     = last_q;
        widx_d     = widx_q;
        accept     = 1'b0;
        issue      = 1'b0;
        pop        = 1'b0;
        push       = dly_vld_q[D-1];
        xfer       = msg_vld_q & fpga_msg_ack;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    sel_d   = bank;
                    addr_d  = '0;
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (credit_q < 3'd4) begin
                    en_d   = 1'b1;
                    issue  = 1'b1;
                    addr_d = addr_q + 1'b1;
                    if (addr_q == AW'(N_ZMW - 2)) state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (xfer && last_q) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Index travels beside each read so it lines up with bram_dout on arrival
        dly_vld_d[0] = en_q;
        dly_idx_d[0] = addr_q;
        for (int i = 1; i < D; i++) begin
            dly_vld_d[i] = dly_vld_q[i-1];
            dly_idx_d[i] = dly_idx_q[i-1];
        end

        if (push) begin
            fifo_idx_d[wr_ptr_q] = dly_idx_q[D-1];
            fifo_dat_d[wr_ptr_q] = bram_dout;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end

        // The output slot reloads whenever it is empty or being taken this edge
        if (!msg_vld_q || fpga_msg_ack) begin
            if (fill_q != 3'd0) begin
                msg_vld_d = 1'b1;
                if (widx_q == '0)
                    msg_d = {8'hA5, sel_q, (XB_SIZE-9)'(fifo_idx_q[rd_ptr_q])};
                for (int w = 1; w <= NW; w++) begin
                    if (widx_q == WCW'(w))
                        msg_d = fifo_dat_q[rd_ptr_q][DATA_SIZE - w*XB_SIZE +: XB_SIZE];
                end
                if (widx_q == WCW'(NW)) begin
                    pop      = 1'b1;
                    widx_d   = '0;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    last_d   = (fifo_idx_q[rd_ptr_q] == AW'(N_ZMW - 1));
                end else begin
                    widx_d = widx_q + 1'b1;
                    last_d = 1'b0;
                end
            end else begin
                msg_vld_d = 1'b0;
                last_d    = 1'b0;
            end
        end

        fill_d   = fill_q + {2'b00, push} - {2'b00, pop};
        credit_d = accept ? 3'd1 : (credit_q + {2'b00, issue} - {2'b00, pop});
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sel_q      <= 1'b0;
            en_q       <= 1'b0;
            addr_q     <= '0;
            credit_q   <= '0;
            dly_vld_q  <= '0;
            dly_idx_q  <= '0;
            fifo_idx_q <= '0;
            fifo_dat_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            msg_vld_q  <= 1'b0;
            msg_q      <= '0;
            last_q     <= 1'b0;
            widx_q     <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sel_q      <= sel_d;
            en_q       <= en_d;
            addr_q     <= addr_d;
            credit_q   <= credit_d;
            dly_vld_q  <= dly_vld_d;
            dly_idx_q  <= dly_idx_d;
            fifo_idx_q <= fifo_idx_d;
            fifo_dat_q <= fifo_dat_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            msg_vld_q  <= msg_vld_d;
            msg_q      <= msg_d;
            last_q     <= last_d;
            widx_q     <= widx_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign bram_sel       = sel_q;
    assign bram_addr      = addr_q;
    assign bram_en        = en_q;
    assign fpga_msg_valid = msg_vld_q;
    assign fpga_msg       = msg_q;

endmodule

// File: doc/pulse_list_reader.md
PULSE_LIST_READER -- requirements
Module: pulse_list_reader

Interface
REQ-001 SHALL have parameter XB_SIZE, default 32: width of one message word to the PC.
REQ-002 SHALL have parameter DATA_SIZE, default 64: width of one pulse-list BRAM entry; an integer multiple of XB_SIZE.
REQ-003 SHALL have parameter N_ZMW, default 128: number of entries per bank.
REQ-004 SHALL have parameter BRAM_READ_DELAY, default 3: cycles from address to valid bram_dout.
REQ-005 SHALL have port CLK, input, 1: sole clock; all logic on its rising edge.
REQ-006 SHALL have port RESET_N, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1: one-cycle request to stream one bank.
REQ-008 SHALL have port bank, input, 1: bank to stream, sampled with start.
REQ-009 SHALL have port busy, output, 1: high from accepted start until done.
REQ-010 SHALL have port done, output, 1: one-cycle pulse after the last word is acked.
REQ-011 SHALL have port bram_sel, output, 1: bank index for the external BRAM read mux.
REQ-012 SHALL have port bram_addr, output, log2(N_ZMW): read address.
REQ-013 SHALL have port bram_en, output, 1: high when bram_addr is a real read.
REQ-014 SHALL have port bram_dout, input, DATA_SIZE: read data, valid BRAM_READ_DELAY cycles after its bram_en cycle.
REQ-015 SHALL have port fpga_msg_valid, output, 1: fpga_msg holds a word.
REQ-016 SHALL have port fpga_msg, output, XB_SIZE: message word.
REQ-017 SHALL have port fpga_msg_ack, input, 1: consumer accepts the current word.

Function
REQ-018 SHALL implement states IDLE, STREAM and FLUSH.
REQ-019 In IDLE, start SHALL latch bank into bram_sel, clear the address and credit counters, and move to STREAM; busy SHALL rise the next cycle.
REQ-020 Start while not IDLE SHALL be ignored, with no effect on the stream in progress.
REQ-021 In STREAM, one read (bram_en=1, bram_addr=next index, ascending from 0) SHALL issue per cycle only while in-flight reads plus FIFO occupancy are below 4.
REQ-022 The read of index N_ZMW-1 SHALL be the last; the address SHALL NOT wrap; the FSM SHALL then enter FLUSH.
REQ-023 A delay line of BRAM_READ_DELAY stages SHALL carry {valid, index} alongside each read and write bram_dout plus index into a 4-entry record FIFO on arrival; FIFO overflow SHALL be impossible by construction.
REQ-024 Each record SHALL be sent as 1+DATA_SIZE/XB_SIZE words: header {8'hA5, bram_sel, index zero-extended to XB_SIZE-9 bits}, then data words most-significant first.
REQ-025 A word SHALL transfer on any edge where fpga_msg_valid and fpga_msg_ack are both high; fpga_msg SHALL stay stable while valid is high and unacked.
REQ-026 After a transfer, the next available word SHALL be presented the following cycle with valid held high, giving 1 word/cycle under continuous ack.
REQ-027 fpga_msg_ack while fpga_msg_valid is low SHALL be ignored.
REQ-028 With start at edge k and BRAM_READ_DELAY=3, fpga_msg_valid SHALL first be high in cycle k+5.
REQ-029 FLUSH SHALL return to IDLE when the last word of record N_ZMW-1 transfers; done SHALL pulse, and busy SHALL drop in the same cycle.
REQ-030 The block SHALL emit exactly N_ZMW records per start, in index order, with no loss or duplication under any ack pattern.

Reset
REQ-031 RESET_N low SHALL immediately force IDLE, emptying the FIFO and delay line; busy, done, bram_en, fpga_msg_valid and bram_sel SHALL be 0, and bram_addr and fpga_msg all-zero.
REQ-032 Reset mid-stream SHALL abort without a done pulse; the first start after release SHALL restart from index 0.

Verification
REQ-033 Test continuous streaming: start, bank=0, ack tied high -> 384 words, one per cycle once the flow is established, headers 0xA5000000..0xA500007F, then a single done pulse.
REQ-034 Test backpressure: random ack at 30% -> identical word sequence, never more than 4 outstanding records, fpga_msg stable while stalled.
REQ-035 Test bank select: bank=1 -> bram_sel=1 throughout, and header bit 23 set (0xA5800000 first).
REQ-036 Test start while busy: start pulsed at word 50 -> ignored, with exactly 384 words and one done pulse.
REQ-037 Test reset mid-stream: RESET_N low at word 100 -> all outputs zero asynchronously and no done; the next start streams from header 0xA5000000.
REQ-038 Test the address end: bram_addr peaks at 127 and bram_en never asserts at address 0 after the last read.
